// File: rtl/pong_game_engine.sv
// Pong game-state engine: PS/2 key decoding, paddle and ball motion on a
// programmable tick, collision/goal detection, scoring and match sequencing.
module pong_game_engine #(
  parameter int FIELD_X0    = 220,
  parameter int FIELD_X1    = 420,
  parameter int FIELD_Y0    = 80,
  parameter int FIELD_Y1    = 450,
  parameter int P1_X        = 220,
  parameter int P2_X        = 400,
  parameter int PADDLE_W    = 20,
  parameter int PADDLE_H    = 80,
  parameter int BALL_R      = 7,
  parameter int BALL_STEP   = 1,
  parameter int PADDLE_STEP = 1,
  parameter int TICK_DIV    = 300000,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [7:0] iScan_code,
  input  logic       iScan_valid,
  input  logic       iHold,
  output logic [9:0] oBall_x,
  output logic [9:0] oBall_y,
  output logic [9:0] oP1_y,
  output logic [9:0] oP2_y,
  output logic [3:0] oP1_score,
  output logic [3:0] oP2_score,
  output logic [2:0] oState,
  output logic       oPoint,
  output logic       oWinner
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SERVE_TICKS + 1);

  localparam logic [9:0] C_BX = 10'((FIELD_X0 + FIELD_X1) / 2);
  localparam logic [9:0] C_BY = 10'((FIELD_Y0 + FIELD_Y1) / 2);
  localparam logic [9:0] C_PY = 10'((FIELD_Y0 + FIELD_Y1 - PADDLE_H) / 2);

  localparam logic signed [10:0] S_X0   = 11'(FIELD_X0);
  localparam logic signed [10:0] S_X1   = 11'(FIELD_X1);
  localparam logic signed [10:0] S_Y0   = 11'(FIELD_Y0);
  localparam logic signed [10:0] S_Y1   = 11'(FIELD_Y1);
  localparam logic signed [10:0] S_P1R  = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0] S_P2X  = 11'(P2_X);
  localparam logic signed [10:0] S_PH   = 11'(PADDLE_H);
  localparam logic signed [10:0] S_PMAX = 11'(FIELD_Y1 - PADDLE_H);
  localparam logic signed [10:0] S_REACH = 11'(BALL_R + BALL_STEP);
  localparam logic signed [10:0] S_PS   = 11'(PADDLE_STEP);

  logic [2:0]    state_q, state_d;
  logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]    p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          dx_r_q, dx_r_d, dy_dn_q, dy_dn_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic          point_q, point_d, winner_q, winner_d, scorer_q, scorer_d;
  logic [3:0]    keys_q, keys_d;   // {p2_dn, p2_up, p1_dn, p1_up}
  logic          brk_q, brk_d;
  logic [3:0]    key_sel;

  logic                tick;
  logic signed [10:0]  bx, by, p1s, p2s;
  logic                hit1, hit2, wall_t, wall_b, goal_l, goal_r, win_now;
  logic [9:0]          p1_mv, p2_mv;

  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = signed'({1'b0, y});
    if (up && !dn)      t = t - S_PS;
    else if (dn && !up) t = t + S_PS;
    if (t < S_Y0)        t = S_Y0;
    else if (t > S_PMAX) t = S_PMAX;
    return t[9:0];
  endfunction

  always_comb begin
    keys_d = keys_q;
    brk_d  = brk_q;
    case (iScan_code)
      8'h1D:   key_sel = 4'b0001;
      8'h1B:   key_sel = 4'b0010;
      8'h43:   key_sel = 4'b0100;
      8'h42:   key_sel = 4'b1000;
      default: key_sel = 4'b0000;
    endcase
    if (iScan_valid && iScan_code != 8'hE0) begin
      if (iScan_code == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        keys_d = brk_q ? (keys_q & ~key_sel) : (keys_q | key_sel);
        brk_d  = 1'b0;
      end
    end
  end

  assign tick  = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign bx    = signed'({1'b0, ball_x_q});
  assign by    = signed'({1'b0, ball_y_q});
  assign p1s   = signed'({1'b0, p1_y_q});
  assign p2s   = signed'({1'b0, p2_y_q});
  assign p1_mv = paddle_next(p1_y_q, keys_q[0], keys_q[1]);
  assign p2_mv = paddle_next(p2_y_q, keys_q[2], keys_q[3]);

  // Every check looks one step ahead of the current position.
  assign hit1   = !dx_r_q && (bx - S_REACH <= S_P1R) && (by >= p1s) && (by <= p1s + S_PH);
  assign hit2   =  dx_r_q && (bx + S_REACH >= S_P2X) && (by >= p2s) && (by <= p2s + S_PH);
  assign wall_t = !dy_dn_q && (by - S_REACH < S_Y0);
  assign wall_b =  dy_dn_q && (by + S_REACH > S_Y1);
  assign goal_l = !dx_r_q && (bx - S_REACH < S_X0) && !hit1;
  assign goal_r =  dx_r_q && (bx + S_REACH > S_X1) && !hit2;
  assign win_now = ((scorer_q ? s2_q : s1_q) == 4'(WIN_SCORE));

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    dx_r_d      = dx_r_q;
    dy_dn_d     = dy_dn_q;
    tick_cnt_d  = tick_cnt_q;
    serve_cnt_d = serve_cnt_q;
    point_d     = 1'b0;
    winner_d    = winner_q;
    scorer_d    = scorer_q;
    if (iHold) begin
      state_d     = ST_IDLE;
      ball_x_d    = C_BX;
      ball_y_d    = C_BY;
      p1_y_d      = C_PY;
      p2_y_d      = C_PY;
      s1_d        = '0;
      s2_d        = '0;
      dx_r_d      = 1'b0;
      dy_dn_d     = 1'b1;
      tick_cnt_d  = '0;
      serve_cnt_d = '0;
      winner_d    = 1'b0;
      scorer_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SERVE;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      case (state_q)
        ST_SERVE: if (tick) begin
          p1_y_d = p1_mv;
          p2_y_d = p2_mv;
          if (serve_cnt_q == SW'(SERVE_TICKS - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + SW'(1);
          end
        end
        ST_PLAY: if (tick) begin
          p1_y_d = p1_mv;
          p2_y_d = p2_mv;
          if (goal_l) begin
            s2_d     = s2_q + 4'd1;
            scorer_d = 1'b1;
            point_d  = 1'b1;
            state_d  = ST_POINT;
          end else if (goal_r) begin
            s1_d     = s1_q + 4'd1;
            scorer_d = 1'b0;
            point_d  = 1'b1;
            state_d  = ST_POINT;
          end else if (hit1 || hit2 || wall_t || wall_b) begin
            if (hit1 || hit2)     dx_r_d  = ~dx_r_q;
            if (wall_t || wall_b) dy_dn_d = ~dy_dn_q;
          end else begin
            ball_x_d = dx_r_q  ? ball_x_q + 10'(BALL_STEP) : ball_x_q - 10'(BALL_STEP);
            ball_y_d = dy_dn_q ? ball_y_q + 10'(BALL_STEP) : ball_y_q - 10'(BALL_STEP);
          end
        end
        ST_POINT: begin
          if (win_now) begin
            state_d  = ST_OVER;
            winner_d = scorer_q;
          end else begin
            // Serve toward whoever conceded.
            state_d     = ST_SERVE;
            ball_x_d    = C_BX;
            ball_y_d    = C_BY;
            dx_r_d      = ~scorer_q;
            dy_dn_d     = 1'b1;
            serve_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= C_BX;
      ball_y_q    <= C_BY;
      p1_y_q      <= C_PY;
      p2_y_q      <= C_PY;
      s1_q        <= '0;
      s2_q        <= '0;
      dx_r_q      <= 1'b0;
      dy_dn_q     <= 1'b1;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      point_q     <= 1'b0;
      winner_q    <= 1'b0;
      scorer_q    <= 1'b0;
      keys_q      <= '0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      p1_y_q      <= p1_y_d;
      p2_y_q      <= p2_y_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      dx_r_q      <= dx_r_d;
      dy_dn_q     <= dy_dn_d;
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      point_q     <= point_d;
      winner_q    <= winner_d;
      scorer_q    <= scorer_d;
      keys_q      <= keys_d;
      brk_q       <= brk_d;
    end
  end

  assign oBall_x   = ball_x_q;
  assign oBall_y   = ball_y_q;
  assign oP1_y     = p1_y_q;
  assign oP2_y     = p2_y_q;
  assign oP1_score = s1_q;
  assign oP2_score = s2_q;
  assign oState    = state_q;
  assign oPoint    = point_q;
  assign oWinner   = winner_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: directed match scenarios plus random key
// traffic, all outputs compared every cycle against a game-rule model.
module tb_pong_game_engine;

  localparam int TD = 4, ST = 2, WS = 2;
  localparam int X0 = 220, X1 = 420, Y0 = 80, Y1 = 450;
  localparam int P1X = 220, P2X = 400, PW = 20, PH = 80, R = 7, BS = 1, PS = 1;
  localparam int CX = (X0 + X1) / 2, CY = (Y0 + Y1) / 2, PY = (Y0 + Y1 - PH) / 2;

  logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0, hold = 1'b1;
  logic [7:0] code = 8'h00;
  logic [9:0] bx, by, p1y, p2y;
  logic [3:0] s1, s2;
  logic [2:0] st;
  logic       pt, win;
  int checks = 0, errors = 0;
  logic [7:0] tbl [0:5] = '{8'h1D, 8'h1B, 8'h43, 8'h42, 8'hF0, 8'hE0};

  always #5 clk = ~clk;

  pong_game_engine #(
    .FIELD_X0(X0), .FIELD_X1(X1), .FIELD_Y0(Y0), .FIELD_Y1(Y1),
    .P1_X(P1X), .P2_X(P2X), .PADDLE_W(PW), .PADDLE_H(PH),
    .BALL_R(R), .BALL_STEP(BS), .PADDLE_STEP(PS),
    .TICK_DIV(TD), .SERVE_TICKS(ST), .WIN_SCORE(WS)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iScan_code(code), .iScan_valid(valid), .iHold(hold),
    .oBall_x(bx), .oBall_y(by), .oP1_y(p1y), .oP2_y(p2y),
    .oP1_score(s1), .oP2_score(s2), .oState(st), .oPoint(pt), .oWinner(win)
  );

  // Game model: state 0..4, directions as +1/-1, scorer 1 or 2.
  int m_state, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_dx, m_dy;
  int m_cnt, m_srv, m_point, m_win, m_scorer;
  bit m_up1, m_dn1, m_up2, m_dn2, m_brk;

  function automatic int pad(input int y, input bit up, input bit dn);
    int t = y;
    if (up && !dn) t -= PS;
    else if (dn && !up) t += PS;
    if (t < Y0) t = Y0;
    if (t > Y1 - PH) t = Y1 - PH;
    return t;
  endfunction

  task automatic m_idle();
    m_state = 0; m_bx = CX; m_by = CY; m_p1 = PY; m_p2 = PY;
    m_s1 = 0; m_s2 = 0; m_dx = -1; m_dy = 1; m_cnt = 0; m_srv = 0;
    m_point = 0; m_win = 0; m_scorer = 1;
  endtask

  task automatic m_reset();
    m_idle();
    m_up1 = 0; m_dn1 = 0; m_up2 = 0; m_dn2 = 0; m_brk = 0;
  endtask

  task automatic m_edge(input bit h, input bit v, input logic [7:0] c);
    bit tick, hit1, hit2, wall, gl, gr;
    m_point = 0;
    if (h) m_idle();
    else if (m_state == 0) m_state = 1;
    else begin
      tick = (m_cnt == TD - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      if (m_state == 1 && tick) begin
        m_p1 = pad(m_p1, m_up1, m_dn1);
        m_p2 = pad(m_p2, m_up2, m_dn2);
        m_srv++;
        if (m_srv == ST) begin m_state = 2; m_srv = 0; end
      end else if (m_state == 2 && tick) begin
        hit1 = m_dx < 0 && m_bx - R - BS <= P1X + PW && m_by >= m_p1 && m_by <= m_p1 + PH;
        hit2 = m_dx > 0 && m_bx + R + BS >= P2X && m_by >= m_p2 && m_by <= m_p2 + PH;
        wall = (m_dy < 0 && m_by - R - BS < Y0) || (m_dy > 0 && m_by + R + BS > Y1);
        gl = m_dx < 0 && m_bx - R - BS < X0 && !hit1;
        gr = m_dx > 0 && m_bx + R + BS > X1 && !hit2;
        if (gl) begin m_s2++; m_scorer = 2; m_point = 1; m_state = 3; end
        else if (gr) begin m_s1++; m_scorer = 1; m_point = 1; m_state = 3; end
        else if (hit1 || hit2 || wall) begin
          if (hit1 || hit2) m_dx = -m_dx;
          if (wall) m_dy = -m_dy;
        end else begin
          m_bx += m_dx * BS; m_by += m_dy * BS;
        end
        m_p1 = pad(m_p1, m_up1, m_dn1);
        m_p2 = pad(m_p2, m_up2, m_dn2);
      end else if (m_state == 3) begin
        if ((m_scorer == 1 ? m_s1 : m_s2) == WS) begin
          m_state = 4; m_win = (m_scorer == 2) ? 1 : 0;
        end else begin
          m_state = 1; m_bx = CX; m_by = CY; m_dy = 1; m_srv = 0;
          m_dx = (m_scorer == 2) ? -1 : 1;
        end
      end
    end
    if (v && c != 8'hE0) begin
      if (c == 8'hF0) m_brk = 1;
      else begin
        case (c)
          8'h1D: m_up1 = !m_brk;
          8'h1B: m_dn1 = !m_brk;
          8'h43: m_up2 = !m_brk;
          8'h42: m_dn2 = !m_brk;
          default: ;
        endcase
        m_brk = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("state", 32'(st), m_state);
    chk("ball_x", 32'(bx), m_bx);
    chk("ball_y", 32'(by), m_by);
    chk("p1_y", 32'(p1y), m_p1);
    chk("p2_y", 32'(p2y), m_p2);
    chk("p1_score", 32'(s1), m_s1);
    chk("p2_score", 32'(s2), m_s2);
    chk("point", 32'(pt), m_point);
    chk("winner", 32'(win), m_win);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge(hold, valid, code);
    #1;
    chk_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] c);
    valid = 1'b1; code = c;
    cyc();
    valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(st), 0);
    chk({tag, "_s1"}, 32'(s1), 0);
    chk({tag, "_s2"}, 32'(s2), 0);
    chk({tag, "_bx"}, 32'(bx), 320);
    chk({tag, "_by"}, 32'(by), 265);
    chk({tag, "_p1"}, 32'(p1y), 225);
    chk({tag, "_p2"}, 32'(p2y), 225);
  endtask

  int fx, fy, fp1, fp2, k;

  initial begin
    m_reset();
    #12;
    chk_all();
    chk_idle("reset");
    chk("reset_point", 32'(pt), 0);
    rst_n = 1'b1;

    // Keys decode in IDLE; first tick lands on the 4th cycle after IDLE.
    send(8'h1D);
    hold = 1'b0;
    cyc(); chk("serve_entry", 32'(st), 1);
    run(3); chk("p1_pre_tick", 32'(p1y), 225);
    cyc();  chk("p1_first_tick", 32'(p1y), 224);
    for (int n = 0; n < 800 && m_p1 != Y0; n++) cyc();
    chk("p1_top", 32'(p1y), 80);
    run(20); chk("p1_clamped", 32'(p1y), 80);
    send(8'hF0); send(8'h1D);
    run(40); chk("p1_released", 32'(p1y), 80);
    for (int n = 0; n < 8 && m_cnt != TD - 1; n++) cyc();
    send(8'h43); send(8'h42);
    run(40); chk("p2_both_held", 32'(p2y), 225);
    send(8'hF0); send(8'h43); send(8'hF0); send(8'h42);

    // Undefended left goal twice: P2 takes the match.
    for (int n = 0; n < 2000 && m_state != 4; n++) cyc();
    chk("over_state", 32'(st), 4);
    chk("over_winner", 32'(win), 1);
    chk("over_s2", 32'(s2), 2);
    chk("over_s1", 32'(s1), 0);
    fx = m_bx; fy = m_by; fp1 = m_p1; fp2 = m_p2;
    send(8'h1B); send(8'h43);
    run(40);
    chk("frozen_bx", 32'(bx), fx);
    chk("frozen_by", 32'(by), fy);
    chk("frozen_p1", 32'(p1y), fp1);
    chk("frozen_p2", 32'(p2y), fp2);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B);
    send(8'hF0); send(8'h43); send(8'hF0); send(8'h42);

    // Fresh match: P1 paddle placed into the ball's path.
    hold = 1'b1;
    cyc(); chk_idle("hold_over");
    send(8'h1B);
    hold = 1'b0;
    for (int n = 0; n < 400 && m_p1 < 280; n++) cyc();
    send(8'hF0); send(8'h1B);
    for (int n = 0; n < 1500 && m_dx != 1; n++) cyc();
    chk("p1_hit_x", 32'(bx), 248);
    for (int n = 0; n < 8 && m_bx == 248; n++) cyc();
    chk("after_hit_x", 32'(bx), 249);
    for (int n = 0; n < 2000 && !(m_s1 == 1 && m_state == 1); n++) cyc();
    chk("p1_scored", 32'(s1), 1);
    send(8'h42);
    for (int n = 0; n < 400 && m_p2 < 280; n++) cyc();
    send(8'hF0); send(8'h42);
    for (int n = 0; n < 3000 && !(m_s2 == 1 && m_state == 2); n++) cyc();
    chk("tie_s1", 32'(s1), 1);
    chk("tie_s2", 32'(s2), 1);
    chk("tie_play", 32'(st), 2);
    run(6);
    hold = 1'b1;
    cyc(); chk_idle("hold_play");
    hold = 1'b0;
    run(22);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 m_reset();
    chk_all();
    chk_idle("async_rst");
    cyc();
    rst_n = 1'b1;

    // Random key traffic with occasional holds.
    for (int i = 0; i < 3000; i++) begin
      hold  = ($urandom_range(0, 999) < 2);
      valid = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 6);
      code = (k == 6) ? 8'($urandom) : tbl[k];
      cyc();
    end
    valid = 1'b0; hold = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
